// File: rtl/alu_multiciclo_pkg.sv
// Shared types and constants for the multi-cycle ALU: opcodes, FSM states
// and the bit positions of the {N,Z,C,V} flag vector.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_MUL = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    MULT = 2'd2,
    DONE = 2'd3
  } estado_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_multiciclo_if.sv
// Operand/result bus of the multi-cycle ALU; the requester is the master,
// the ALU is the slave.
interface alu_multiciclo_if #(parameter int N_BITS = 8);

  logic [N_BITS-1:0] entrada_a;
  logic [N_BITS-1:0] entrada_b;
  logic [2:0]        operacion;
  logic              inicio;
  logic              ocupado;
  logic              listo;
  logic [N_BITS-1:0] resultado;
  logic [3:0]        flags;

  modport master (
    output entrada_a, entrada_b, operacion, inicio,
    input  ocupado, listo, resultado, flags
  );

  modport slave (
    input  entrada_a, entrada_b, operacion, inicio,
    output ocupado, listo, resultado, flags
  );

endinterface

// File: rtl/alu_multiciclo_multiplicador_iterativo.sv
// Unsigned shift-add multiplier, one partial product per clock, paced by a
// down-counter; producto already includes the current iteration's addend.
module multiplicador_iterativo #(
  parameter int N_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [N_BITS-1:0]     a,
  input  logic [N_BITS-1:0]     b,
  output logic [2*N_BITS-1:0]   producto,
  output logic                  done
);

  localparam int CNT_W = $clog2(N_BITS + 1);

  logic [2*N_BITS-1:0] acc;
  logic [2*N_BITS-1:0] mcand;
  logic [N_BITS-1:0]   mplier;
  logic [CNT_W-1:0]    cnt;
  logic [2*N_BITS-1:0] acc_next;

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign producto = acc_next;
  // Terminal count: the edge that consumes the last multiplier bit.
  assign done     = (cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{N_BITS{1'b0}}, a};
      mplier <= b;
      cnt    <= CNT_W'(N_BITS);
    end else if (cnt != '0) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_multiciclo.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops via CALC, iterative
// multiply via MULT, one-cycle listo pulse from DONE.
//
// state | meaning
// IDLE  | waiting for inicio; operands latched on acceptance
// CALC  | single-cycle op evaluated, result/flags written on exit
// MULT  | shift-add iterations; result/flags written on the last one
// DONE  | listo high for this cycle, then back to IDLE
module alu_multiciclo
  import alu_pkg::*;
#(
  parameter int N_BITS = 8
) (
  input  logic               clk,
  input  logic               reset,
  alu_multiciclo_if.slave    bus
);

  localparam int MSB  = N_BITS - 1;
  localparam int SH_W = $clog2(N_BITS);

  estado_t             estado;
  op_t                 op_r;
  logic [N_BITS-1:0]   op_a;
  logic [N_BITS-1:0]   op_b;

  logic                mul_start;
  logic                mul_done;
  logic [2*N_BITS-1:0] mul_producto;

  logic [N_BITS:0]     suma;
  logic [N_BITS-1:0]   alu_res;
  logic                alu_c;
  logic                alu_v;
  logic [3:0]          alu_flags;

  assign mul_start = (estado == IDLE) && bus.inicio && (op_t'(bus.operacion) == OP_MUL);

  multiplicador_iterativo #(.N_BITS(N_BITS)) u_mult (
    .clk      (clk),
    .reset    (reset),
    .start    (mul_start),
    .a        (bus.entrada_a),
    .b        (bus.entrada_b),
    .producto (mul_producto),
    .done     (mul_done)
  );

  always_comb begin
    suma    = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_r)
      OP_ADD: begin
        suma    = {1'b0, op_a} + {1'b0, op_b};
        alu_res = suma[N_BITS-1:0];
        alu_c   = suma[N_BITS];
        alu_v   = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end
      OP_SUB: begin
        suma    = {1'b0, op_a} + {1'b0, ~op_b} + (N_BITS + 1)'(1);
        alu_res = suma[N_BITS-1:0];
        alu_c   = suma[N_BITS];
        alu_v   = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SHL:  alu_res = op_a << op_b[SH_W-1:0];
      OP_MUL: begin
        alu_res = mul_producto[N_BITS-1:0];
        alu_v   = |mul_producto[2*N_BITS-1:N_BITS];
      end
      default: alu_res = '0;
    endcase
    alu_flags         = '0;
    alu_flags[FLAG_N] = alu_res[MSB];
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_V] = alu_v;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado        <= IDLE;
      op_r          <= OP_NOP;
      op_a          <= '0;
      op_b          <= '0;
      bus.resultado <= '0;
      bus.flags     <= '0;
      bus.ocupado   <= 1'b0;
      bus.listo     <= 1'b0;
    end else begin
      bus.listo <= 1'b0;
      case (estado)
        IDLE: begin
          if (bus.inicio) begin
            op_r        <= op_t'(bus.operacion);
            op_a        <= bus.entrada_a;
            op_b        <= bus.entrada_b;
            bus.ocupado <= 1'b1;
            estado      <= (op_t'(bus.operacion) == OP_MUL) ? MULT : CALC;
          end
        end
        CALC: begin
          bus.resultado <= alu_res;
          bus.flags     <= alu_flags;
          bus.listo     <= 1'b1;
          estado        <= DONE;
        end
        MULT: begin
          if (mul_done) begin
            bus.resultado <= alu_res;
            bus.flags     <= alu_flags;
            bus.listo     <= 1'b1;
            estado        <= DONE;
          end
        end
        DONE: begin
          bus.ocupado <= 1'b0;
          estado      <= IDLE;
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Self-checking bench for alu_multiciclo (N_BITS=8): vector table, random ops
// against a reference model, and hand-written hold/reset sequences.
module tb_alu_multiciclo;
  import alu_pkg::*;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] fl;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic [3:0] fl;
    int         acc;
    int         lat;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic prev_listo = 1'b0;
  exp_t sb[$];

  alu_multiciclo_if #(.N_BITS(8)) bus ();

  alu_multiciclo #(.N_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: integer arithmetic, returns {flags, result}.
  function automatic logic [11:0] model(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    int ia = a;
    int ib = b;
    int sa = $signed(a);
    int sb_ = $signed(b);
    int r = 0;
    int s;
    bit c = 0;
    bit v = 0;
    logic [7:0] res;
    case (op)
      3'b001: begin r = ia + ib; c = (r > 255); s = sa + sb_; v = (s > 127) || (s < -128); end
      3'b010: begin r = ia - ib; c = (ia >= ib); s = sa - sb_; v = (s > 127) || (s < -128); end
      3'b011: r = ia & ib;
      3'b100: r = ia | ib;
      3'b101: r = ia ^ ib;
      3'b110: r = ia << (ib % 8);
      3'b111: begin r = ia * ib; v = (r > 255); end
      default: r = 0;
    endcase
    res = r[7:0];
    return {res[7], (res == 8'h00), c, v, res};
  endfunction

  always @(negedge clk) begin
    if (bus.listo) begin
      chk("listo_width", {31'b0, prev_listo}, 32'd0);
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_listo: got listo=1 expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_res"}, {24'b0, bus.resultado}, {24'b0, e.res});
        chk({e.name, "_flags"}, {28'b0, bus.flags}, {28'b0, e.fl});
        chk({e.name, "_lat"}, cyc - e.acc, e.lat);
      end
    end
    prev_listo = bus.listo;
  end

  task automatic wait_idle(string nm);
    int n = 0;
    while (bus.ocupado && n < 50) begin @(negedge clk); n++; end
    if (bus.ocupado) begin
      errors++;
      $display("FAIL %s_idle_timeout: got ocupado=1 expected 0", nm);
    end
  endtask

  task automatic drain(string nm);
    int n = 0;
    while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL %s_listo_timeout: got %0d pending expected 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic run_op(string nm, logic [2:0] op, logic [7:0] a, logic [7:0] b,
                        logic [7:0] er, logic [3:0] ef);
    exp_t e;
    @(negedge clk);
    wait_idle(nm);
    bus.operacion = op;
    bus.entrada_a = a;
    bus.entrada_b = b;
    bus.inicio    = 1'b1;
    e.res = er; e.fl = ef; e.acc = cyc + 1; e.lat = (op == 3'b111) ? 8 : 1; e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    bus.inicio    = 1'b0;
    chk({nm, "_ocupado"}, {31'b0, bus.ocupado}, 32'd1);
    bus.entrada_a = 8'($urandom);
    bus.entrada_b = 8'($urandom);
    bus.operacion = 3'($urandom);
    drain(nm);
  endtask

  vec_t vecs[15];

  initial begin
    exp_t e;
    int k;
    logic [11:0] m;
    logic [2:0] rop;
    logic [7:0] ra, rb;

    //          op      a      b      res    {N,Z,C,V}
    vecs[0]  = '{3'b001, 8'h7F, 8'h01, 8'h80, 4'b1001};
    vecs[1]  = '{3'b010, 8'h05, 8'h05, 8'h00, 4'b0110};
    vecs[2]  = '{3'b010, 8'h00, 8'h01, 8'hFF, 4'b1000};
    vecs[3]  = '{3'b111, 8'h0F, 8'h11, 8'hFF, 4'b1000};
    vecs[4]  = '{3'b111, 8'h10, 8'h10, 8'h00, 4'b0101};
    vecs[5]  = '{3'b110, 8'h81, 8'h0B, 8'h08, 4'b0000};
    vecs[6]  = '{3'b000, 8'h12, 8'h34, 8'h00, 4'b0100};
    vecs[7]  = '{3'b011, 8'hF0, 8'h3C, 8'h30, 4'b0000};
    vecs[8]  = '{3'b100, 8'hF0, 8'h0F, 8'hFF, 4'b1000};
    vecs[9]  = '{3'b101, 8'hAA, 8'hAA, 8'h00, 4'b0100};
    vecs[10] = '{3'b001, 8'hFF, 8'h01, 8'h00, 4'b0110};
    vecs[11] = '{3'b010, 8'h80, 8'h01, 8'h7F, 4'b0011};
    vecs[12] = '{3'b111, 8'hFF, 8'hFF, 8'h01, 4'b0001};
    vecs[13] = '{3'b110, 8'h01, 8'h07, 8'h80, 4'b1000};
    vecs[14] = '{3'b001, 8'h80, 8'h80, 8'h00, 4'b0111};

    bus.inicio = 1'b0; bus.entrada_a = '0; bus.entrada_b = '0; bus.operacion = '0;
    repeat (3) @(negedge clk);
    chk("rst_ocupado", {31'b0, bus.ocupado}, 32'd0);
    chk("rst_listo", {31'b0, bus.listo}, 32'd0);
    chk("rst_resultado", {24'b0, bus.resultado}, 32'd0);
    chk("rst_flags", {28'b0, bus.flags}, 32'd0);
    reset = 1'b0;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].fl);

    for (int i = 0; i < 20; i++) begin
      rop = 3'($urandom); ra = 8'($urandom); rb = 8'($urandom);
      m = model(rop, ra, rb);
      run_op($sformatf("rnd%0d", i), rop, ra, rb, m[7:0], m[11:8]);
    end

    // inicio held through a MUL while operands switch to an ADD.
    @(negedge clk);
    wait_idle("hold");
    bus.operacion = 3'b111; bus.entrada_a = 8'h03; bus.entrada_b = 8'h05; bus.inicio = 1'b1;
    k = cyc + 1;
    e.res = 8'h0F; e.fl = 4'b0000; e.acc = k; e.lat = 8; e.name = "hold_mul";
    sb.push_back(e);
    @(negedge clk);
    bus.operacion = 3'b001; bus.entrada_a = 8'h01; bus.entrada_b = 8'h01;
    e.res = 8'h02; e.fl = 4'b0000; e.acc = k + 10; e.lat = 1; e.name = "hold_add";
    sb.push_back(e);
    while (cyc < k + 9) @(negedge clk);
    chk("hold_idle_gap", {31'b0, bus.ocupado}, 32'd0);
    @(negedge clk);
    bus.inicio = 1'b0;
    drain("hold");

    // Reset at MULT iteration 4 discards the multiply.
    @(negedge clk);
    wait_idle("rstmul");
    bus.operacion = 3'b111; bus.entrada_a = 8'h0F; bus.entrada_b = 8'h11; bus.inicio = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    bus.inicio = 1'b0;
    while (cyc < k + 3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmul_ocupado", {31'b0, bus.ocupado}, 32'd0);
    chk("rstmul_resultado", {24'b0, bus.resultado}, 32'd0);
    chk("rstmul_flags", {28'b0, bus.flags}, 32'd0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    run_op("post_rst_add", 3'b001, 8'h02, 8'h03, 8'h05, 4'b0000);

    // Reset wins over a same-edge acceptance.
    @(negedge clk);
    bus.operacion = 3'b001; bus.entrada_a = 8'h01; bus.entrada_b = 8'h01;
    bus.inicio = 1'b1; reset = 1'b1;
    @(negedge clk);
    bus.inicio = 1'b0; reset = 1'b0;
    chk("rst_vs_accept_ocupado", {31'b0, bus.ocupado}, 32'd0);
    repeat (4) @(negedge clk);
    run_op("final_sub", 3'b010, 8'h10, 8'h20, 8'hF0, 4'b1000);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500000");
    $fatal(1);
  end

endmodule
